shot_tracer: RTL and testbench

- Consumer of the aim interface: on a fire request, latches the shooter's column and the aim slope (x_pos, run, rise, dir).
- Walks a projectile cell by cell across the 32-column playfield using an integer Bresenham line, one cell per step tick.
- Reports a hit against the target cell, or a miss when the shot leaves the grid.
- Feeds the renderer (shot_x/shot_y/shot_active) and game-score logic (hit/miss pulses).

---
 rtl/shot_tracer.sv | 143 ++++++++++++++
 tb/tb_shot_tracer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/shot_tracer.sv
// shot_tracer: launches a projectile on a fire request and walks it across the
// 32-column playfield with an integer Bresenham line. The projectile advances
// one cell per step tick. A one-cycle hit pulse marks the target cell, and a
// one-cycle miss pulse marks the shot leaving the grid.
//
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   fire, step         launch request and advance tick
//   x_pos, run, rise   launch column and slope magnitudes
//   dir                1 = x increasing, 0 = x decreasing
//   target_x/target_y  target cell, sampled live on every step
//   shot_x/shot_y      current or final projectile cell
//   shot_active        projectile in flight
//   hit, miss          one-cycle result pulses
module shot_tracer #(
  parameter int unsigned ROWS = 16,
  parameter int unsigned Y_W  = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           fire,
  input  logic           step,
  input  logic [4:0]     x_pos,
  input  logic [4:0]     run,
  input  logic [4:0]     rise,
  input  logic           dir,
  input  logic [4:0]     target_x,
  input  logic [Y_W-1:0] target_y,
  output logic [4:0]     shot_x,
  output logic [Y_W-1:0] shot_y,
  output logic           shot_active,
  output logic           hit,
  output logic           miss
);

  localparam int unsigned X_W   = 5;
  localparam int unsigned ACC_W = 6;
  localparam int unsigned XE_W  = X_W + 2;  // room for -1 and 32
  localparam int unsigned YE_W  = Y_W + 1;  // room for ROWS

  typedef enum logic {IDLE, FLY} state_t;

  state_t           state_q;
  logic [X_W-1:0]   x_q;
  logic [Y_W-1:0]   y_q;
  logic [ACC_W-1:0] acc_q;
  logic [X_W-1:0]   dx_q;
  logic [X_W-1:0]   dy_q;
  logic             sx_q;
  logic             active_q;
  logic             hit_q;
  logic             miss_q;

  logic [XE_W-1:0]  x_mv_d;
  logic [YE_W-1:0]  y_inc_d;
  logic             x_major_d;
  logic [ACC_W-1:0] acc_sum_d;
  logic [ACC_W-1:0] major_d;
  logic             carry_d;
  logic [ACC_W-1:0] acc_d;
  logic [XE_W-1:0]  nx_d;
  logic [YE_W-1:0]  ny_d;
  logic             oob_d;
  logic             on_tgt_d;

  // Candidate next cell from one Bresenham step.
  always_comb begin
    x_mv_d    = sx_q ? (XE_W'(x_q) + XE_W'(1)) : (XE_W'(x_q) - XE_W'(1));
    y_inc_d   = YE_W'(y_q) + YE_W'(1);
    x_major_d = (dx_q > dy_q);
    major_d   = x_major_d ? ACC_W'(dx_q) : ACC_W'(dy_q);
    acc_sum_d = acc_q + (x_major_d ? ACC_W'(dy_q) : ACC_W'(dx_q));
    carry_d   = (acc_sum_d >= major_d);
    acc_d     = carry_d ? (acc_sum_d - major_d) : acc_sum_d;
    nx_d      = (x_major_d || carry_d) ? x_mv_d : XE_W'(x_q);
    ny_d      = (!x_major_d || carry_d) ? y_inc_d : YE_W'(y_q);
    // Any bit above the column field means the column went below 0 or above 31.
    oob_d     = (nx_d[XE_W-1:X_W] != '0) || (ny_d > YE_W'(ROWS - 1));
    on_tgt_d  = (nx_d[X_W-1:0] == target_x) && (ny_d[Y_W-1:0] == target_y);
  end

  // Launch/flight control with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sx_q     <= 1'b0;
      active_q <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A zero slope has no direction, so that fire request is dropped.
          if (fire && ((run != '0) || (rise != '0))) begin
            dx_q     <= run;
            dy_q     <= rise;
            sx_q     <= dir;
            x_q      <= x_pos;
            y_q      <= '0;
            acc_q    <= '0;
            active_q <= 1'b1;
            state_q  <= FLY;
          end
        end
        FLY: begin
          if (step) begin
            if (oob_d) begin
              // Hold the last in-bounds cell for the renderer.
              miss_q   <= 1'b1;
              active_q <= 1'b0;
              state_q  <= IDLE;
            end else if (on_tgt_d) begin
              x_q      <= nx_d[X_W-1:0];
              y_q      <= ny_d[Y_W-1:0];
              hit_q    <= 1'b1;
              active_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              x_q   <= nx_d[X_W-1:0];
              y_q   <= ny_d[Y_W-1:0];
              acc_q <= acc_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign shot_x      = x_q;
  assign shot_y      = y_q;
  assign shot_active = active_q;
  assign hit         = hit_q;
  assign miss        = miss_q;

endmodule

// File: tb/tb_shot_tracer.sv
// Directed-vector bench for shot_tracer. Each table record is one clock cycle:
// the inputs to apply and the outputs expected after the following edge.
module tb_shot_tracer;

  localparam int unsigned Y_W = 4;

  logic           clk;
  logic           reset;
  logic           fire;
  logic           step;
  logic [4:0]     x_pos;
  logic [4:0]     run;
  logic [4:0]     rise;
  logic           dir;
  logic [4:0]     target_x;
  logic [Y_W-1:0] target_y;
  logic [4:0]     shot_x;
  logic [Y_W-1:0] shot_y;
  logic           shot_active;
  logic           hit;
  logic           miss;

  shot_tracer #(.ROWS(16), .Y_W(Y_W)) dut (
    .clk(clk), .reset(reset), .fire(fire), .step(step),
    .x_pos(x_pos), .run(run), .rise(rise), .dir(dir),
    .target_x(target_x), .target_y(target_y),
    .shot_x(shot_x), .shot_y(shot_y), .shot_active(shot_active),
    .hit(hit), .miss(miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           fire;
    logic           step;
    logic [4:0]     xp;
    logic [4:0]     run;
    logic [4:0]     rise;
    logic           dir;
    logic [4:0]     tx;
    logic [Y_W-1:0] ty;
    logic [4:0]     ex;
    logic [Y_W-1:0] ey;
    logic           ea;
    logic           eh;
    logic           em;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic f, input logic s, input int xp, input int rn,
                     input int rs, input logic d, input int tx, input int ty,
                     input int ex, input int ey, input logic ea, input logic eh,
                     input logic em);
    vec_t v;
    v.fire = f;  v.step = s;
    v.xp = 5'(xp); v.run = 5'(rn); v.rise = 5'(rs); v.dir = d;
    v.tx = 5'(tx); v.ty = Y_W'(ty);
    v.ex = 5'(ex); v.ey = Y_W'(ey); v.ea = ea; v.eh = eh; v.em = em;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [4:0] ex,
                       input logic [Y_W-1:0] ey, input logic ea,
                       input logic eh, input logic em);
    n_vec++;
    if (shot_x !== ex || shot_y !== ey || shot_active !== ea ||
        hit !== eh || miss !== em) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d act=%b hit=%b miss=%b, want x=%0d y=%0d act=%b hit=%b miss=%b",
               name, shot_x, shot_y, shot_active, hit, miss, ex, ey, ea, eh, em);
    end
  endtask

  task automatic drive(input vec_t v);
    fire = v.fire; step = v.step; x_pos = v.xp; run = v.run; rise = v.rise;
    dir = v.dir; target_x = v.tx; target_y = v.ty;
  endtask

  // Drive one record, clock it, sample 1 time unit after the edge.
  task automatic apply(input string name, input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    check(name, v.ex, v.ey, v.ea, v.eh, v.em);
  endtask

  initial begin
    // Vertical shot straight up column 10, leaves the top after 16 steps.
    add(1,0, 10,0,1,0, 31,15, 10,0, 1,0,0);
    for (int i = 1; i <= 15; i++) add(0,1, 10,0,1,0, 31,15, 10,i, 1,0,0);
    add(0,1, 10,0,1,0, 31,15, 10,15, 0,0,1);
    add(0,0, 10,0,1,0, 31,15, 10,15, 0,0,0);
    // Zero slope fire is dropped; a step in IDLE does nothing.
    add(1,0, 3,0,0,1, 31,15, 10,15, 0,0,0);
    add(0,1, 3,0,0,1, 31,15, 10,15, 0,0,0);
    // Diagonal hit at (13,3); idle cycle holds; fire in flight is ignored.
    add(1,0, 10,1,1,1, 13,3, 10,0, 1,0,0);
    add(0,0, 10,1,1,1, 13,3, 10,0, 1,0,0);
    add(0,1, 10,1,1,1, 13,3, 11,1, 1,0,0);
    add(1,1, 2,5,0,0,  13,3, 12,2, 1,0,0);
    add(1,0, 2,5,0,0,  13,3, 12,2, 1,0,0);
    add(0,1, 10,1,1,1, 13,3, 13,3, 0,1,0);
    add(0,0, 10,1,1,1, 13,3, 13,3, 0,0,0);
    // Steep slope, then the target moves onto the path mid-flight.
    add(1,0, 5,1,2,1, 31,15, 5,0, 1,0,0);
    add(0,1, 5,1,2,1, 31,15, 5,1, 1,0,0);
    add(0,1, 5,1,2,1, 31,15, 6,2, 1,0,0);
    add(0,1, 5,1,2,1, 31,15, 6,3, 1,0,0);
    add(0,1, 5,1,2,1, 31,15, 7,4, 1,0,0);
    add(0,1, 5,1,2,1, 7,5,   7,5, 0,1,0);
    // Fire and step together in IDLE launch without stepping; left-edge exit.
    add(1,1, 1,2,1,0, 31,15, 1,0, 1,0,0);
    add(0,1, 1,2,1,0, 31,15, 0,0, 1,0,0);
    add(0,1, 1,2,1,0, 31,15, 0,0, 0,0,1);
    // Back-to-back launch right after the miss; x-major hit on row 0.
    add(1,0, 20,3,1,1, 22,0, 20,0, 1,0,0);
    add(0,1, 20,3,1,1, 22,0, 21,0, 1,0,0);
    add(0,1, 20,3,1,1, 22,0, 22,0, 0,1,0);
    // Flat shot off the right edge.
    add(1,0, 30,1,0,1, 0,15, 30,0, 1,0,0);
    add(0,1, 30,1,0,1, 0,15, 31,0, 1,0,0);
    add(0,1, 30,1,0,1, 0,15, 31,0, 0,0,1);
    add(0,0, 30,1,0,1, 0,15, 31,0, 0,0,0);

    reset = 1'b1;
    fire = 1'b0; step = 1'b0; x_pos = '0; run = '0; rise = '0; dir = 1'b0;
    target_x = '0; target_y = '0;
    #12;
    check("reset_state", 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Asynchronous reset three steps into a flight.
    begin
      vec_t v;
      v = vecs[0];
      v.fire = 1; v.step = 0; v.xp = 10; v.run = 1; v.rise = 1; v.dir = 1;
      v.tx = 31; v.ty = 15; v.ex = 10; v.ey = 0; v.ea = 1; v.eh = 0; v.em = 0;
      apply("mid_launch", v);
      v.fire = 0; v.step = 1;
      for (int i = 1; i <= 3; i++) begin
        v.ex = 5'(10 + i); v.ey = Y_W'(i);
        apply($sformatf("mid_step%0d", i), v);
      end
      #2;
      reset = 1'b1;
      #1;
      check("rst_async", 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      fire = 1'b1;
      @(posedge clk);
      #1;
      check("rst_hold", 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      fire = 1'b0;
      step = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_idle", 5'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      v.fire = 1; v.step = 0; v.xp = 4; v.run = 0; v.rise = 1;
      v.ex = 4; v.ey = 0; v.ea = 1;
      apply("post_rst_fire", v);
      v.fire = 0; v.step = 1; v.ey = 1;
      apply("post_rst_step", v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
